execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the RV32 pipeline, directly downstream of register-file read. It takes decoded fields and operand data and computes ALU results, load/store addresses, branch decisions and jump targets. An iterative multi-cycle multiplier handles MUL. Results go to load/store through a registered valid/ready output slot.

## Interface
- BUS_WIDTH, 32, data/address width
- REG_WIDTH, 5, register index width
- INSTR_TYPE_WIDTH, 8, decoded instruction-type code width

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- flush  in  1  synchronous kill of held/in-progress op
- in_valid  in  1  upstream op present
- in_ready  out  1  stage can accept (combinational)
- pc_in  in  BUS_WIDTH  word-address PC of op
- instr_type_in  in  INSTR_TYPE_WIDTH  decoded type code
- rd_in  in  REG_WIDTH  destination register
- rde_in  in  1  destination write enable
- imm_in  in  BUS_WIDTH  sign-extended immediate (words for branches/jumps)
- rs1_data_in, rs2_data_in  in  BUS_WIDTH  operand data
- out_valid  out  1  result slot full
- out_ready  in  1  downstream accepts
- pc_out  out  BUS_WIDTH  pass-through PC
- instr_type_out  out  INSTR_TYPE_WIDTH  pass-through type
- rd_out  out  REG_WIDTH  pass-through rd
- rde_out  out  1  rde, forced 0 for stores/branches/unknown codes
- result  out  BUS_WIDTH  ALU result / memory address / link value
- store_data  out  BUS_WIDTH  rs2 data for SW, else 0
- br_taken  out  1  redirect required (valid only with out_valid)
- br_target  out  BUS_WIDTH  redirect PC

## Operation
- Codes 0x01–0x0A: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU; B = rs2_data_in.
- Codes 0x11–0x1A: same ops with B = imm_in. SUB-imm (0x12) computes rs1−imm.
- Shifts use B[4:0]. SLT is signed; SLTU is unsigned; result is 0 or 1.
- 0x20 LW: result = rs1+imm.
- 0x21 SW: result = rs1+imm, store_data = rs2, rde_out = 0.
- 0x30–0x35 BEQ/BNE/BLT/BGE/BLTU/BGEU: br_taken = condition, br_target = pc+imm, result = 0, rde_out = 0.
- 0x38 JAL: result = pc+1, br_taken = 1, br_target = pc+imm.
- 0x39 JALR: result = pc+1, br_taken = 1, br_target = rs1+imm.
- 0x40 LUI: result = imm. 0x41 AUIPC: result = pc+imm.
- 0x50 MUL: low BUS_WIDTH bits of rs1×rs2, computed by shift-add, one bit per cycle.
- 0x00 and any other code: NOP, result = 0, rde_out = 0, br_taken = 0.
- All arithmetic is modulo 2^BUS_WIDTH. Overflow is ignored.
- br_taken = 0 and br_target = 0 when the op is not a branch or jump.

State machine:
- IDLE: output slot empty.
- FULL: output slot holds a result.
- MUL: multiply in progress, with a counter.
- Transitions:
  - IDLE/FULL accept of a non-MUL op → FULL.
  - IDLE/FULL accept of MUL → MUL, counter = BUS_WIDTH, operands latched.
  - MUL: each edge does one iteration and decrements the counter. The iteration that brings the counter to 0 writes the product → FULL.
  - FULL with out_ready = 1 and no accept → IDLE.
- in_ready = reset & !flush & (state != MUL) & (!out_valid | out_ready).
- Accept happens on an edge with in_valid & in_ready.

## Timing
- Reset (reset = 0 at edge): state IDLE, out_valid = 0, all data outputs 0, MUL counter 0. in_ready = 0 while reset = 0.
- Non-MUL op accepted at the edge ending cycle c → out_valid = 1 in cycle c+1 (latency 1).
- MUL accepted at the edge ending cycle c → out_valid = 1 in cycle c+BUS_WIDTH+1. in_ready = 0 from cycle c+1 until out_valid rises.
- Output fields are stable while out_valid = 1 and out_ready = 0.
- Full slot with out_ready = 1 and in_valid = 1 in the same cycle: the old result is consumed and the new op is accepted. Throughput is 1 op/cycle for non-MUL ops.
- flush = 1 at an edge:
  - out_valid → 0 and state → IDLE, including mid-MUL.
  - No accept that cycle.
  - flush has priority over out_ready and in_valid.
- Reset mid-MUL aborts the multiply. No result is produced.
- out_valid is never asserted during reset or in the cycle after a flush unless a new accept occurred. No accept occurs during a flush.

## Test plan
- ADD 5+7, SUB 3−5, SRA 0x80000000>>4, SLTU 1<0xFFFFFFFF, each issued back-to-back with out_ready = 1 → results 12, 0xFFFFFFFE, 0xF8000000, 1, one per cycle, latency 1.
- BLT with rs1 = −1, rs2 = 1, pc = 0x10, imm = −4 → br_taken = 1, br_target = 0x0C, rde_out = 0. The same op as BLTU → br_taken = 0.
- JALR with pc = 0x20, rs1 = 0x100, imm = 4 → result = 0x21, br_target = 0x104, br_taken = 1.
- MUL 0xFFFFFFFF × 3 → result = 0xFFFFFFFD, out_valid exactly BUS_WIDTH+1 cycles after accept. in_ready stays 0 throughout the multiply.
- out_ready = 0 for 5 cycles with a held SW (rs1 = 0x40, imm = 8, rs2 = 0xAB) → outputs stable at result = 0x48, store_data = 0xAB. in_ready = 0 until out_ready = 1.
- flush at iteration 10 of a MUL, and separately reset = 0 mid-MUL → out_valid stays 0, state IDLE. The next ADD completes with latency 1.

Source files
------------

// File: rtl/execute_stage.sv
// RV32 execute stage: single-cycle ALU/branch/jump/address ops plus an iterative shift-add MUL,
// feeding a registered valid/ready result slot.
module execute_stage #(
    parameter int unsigned BUS_WIDTH        = 32,
    parameter int unsigned REG_WIDTH        = 5,
    parameter int unsigned INSTR_TYPE_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BUS_WIDTH-1:0]        pc_in,
    input  logic [INSTR_TYPE_WIDTH-1:0] instr_type_in,
    input  logic [REG_WIDTH-1:0]        rd_in,
    input  logic                        rde_in,
    input  logic [BUS_WIDTH-1:0]        imm_in,
    input  logic [BUS_WIDTH-1:0]        rs1_data_in,
    input  logic [BUS_WIDTH-1:0]        rs2_data_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BUS_WIDTH-1:0]        pc_out,
    output logic [INSTR_TYPE_WIDTH-1:0] instr_type_out,
    output logic [REG_WIDTH-1:0]        rd_out,
    output logic                        rde_out,
    output logic [BUS_WIDTH-1:0]        result,
    output logic [BUS_WIDTH-1:0]        store_data,
    output logic                        br_taken,
    output logic [BUS_WIDTH-1:0]        br_target
);

    localparam int unsigned CntW = $clog2(BUS_WIDTH + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(BUS_WIDTH);

    localparam logic [INSTR_TYPE_WIDTH-1:0] TypeLw    = INSTR_TYPE_WIDTH'('h20);
    localparam logic [INSTR_TYPE_WIDTH-1:0] TypeSw    = INSTR_TYPE_WIDTH'('h21);
    localparam logic [INSTR_TYPE_WIDTH-1:0] TypeBeq   = INSTR_TYPE_WIDTH'('h30);
    localparam logic [INSTR_TYPE_WIDTH-1:0] TypeBne   = INSTR_TYPE_WIDTH'('h31);
    localparam logic [INSTR_TYPE_WIDTH-1:0] TypeBlt   = INSTR_TYPE_WIDTH'('h32);
    localparam logic [INSTR_TYPE_WIDTH-1:0] TypeBge   = INSTR_TYPE_WIDTH'('h33);
    localparam logic [INSTR_TYPE_WIDTH-1:0] TypeBltu  = INSTR_TYPE_WIDTH'('h34);
    localparam logic [INSTR_TYPE_WIDTH-1:0] TypeBgeu  = INSTR_TYPE_WIDTH'('h35);
    localparam logic [INSTR_TYPE_WIDTH-1:0] TypeJal   = INSTR_TYPE_WIDTH'('h38);
    localparam logic [INSTR_TYPE_WIDTH-1:0] TypeJalr  = INSTR_TYPE_WIDTH'('h39);
    localparam logic [INSTR_TYPE_WIDTH-1:0] TypeLui   = INSTR_TYPE_WIDTH'('h40);
    localparam logic [INSTR_TYPE_WIDTH-1:0] TypeAuipc = INSTR_TYPE_WIDTH'('h41);
    localparam logic [INSTR_TYPE_WIDTH-1:0] TypeMul   = INSTR_TYPE_WIDTH'('h50);

    typedef enum logic [1:0] {StIdle, StFull, StMul} state_e;

    state_e state_q, state_d;

    logic [CntW-1:0]             cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0]        mul_acc_q, mul_acc_d;
    logic [BUS_WIDTH-1:0]        mul_mcand_q, mul_mcand_d;
    logic [BUS_WIDTH-1:0]        mul_mplier_q, mul_mplier_d;
    logic [BUS_WIDTH-1:0]        mul_acc_step;
    logic                        mul_done;

    logic [BUS_WIDTH-1:0]        pc_q, pc_d;
    logic [INSTR_TYPE_WIDTH-1:0] type_q, type_d;
    logic [REG_WIDTH-1:0]        rd_q, rd_d;
    logic                        rde_q, rde_d;
    logic [BUS_WIDTH-1:0]        result_q, result_d;
    logic [BUS_WIDTH-1:0]        store_q, store_d;
    logic                        br_taken_q, br_taken_d;
    logic [BUS_WIDTH-1:0]        br_target_q, br_target_d;

    logic                        accept;
    logic                        is_alu;
    logic [BUS_WIDTH-1:0]        alu_b, alu_res;
    logic [4:0]                  shamt;
    logic [BUS_WIDTH-1:0]        addr_sum, pc_imm, pc_inc;
    logic                        slt_ab, sltu_ab, br_eq, br_lt, br_ltu;
    logic [BUS_WIDTH-1:0]        dec_result, dec_store, dec_br_target;
    logic                        dec_rde, dec_br_taken, dec_is_mul;

    always_comb begin
        // Bit 4 of an ALU code selects the immediate as the second operand.
        alu_b    = instr_type_in[4] ? imm_in : rs2_data_in;
        shamt    = alu_b[4:0];
        addr_sum = rs1_data_in + imm_in;
        pc_imm   = pc_in + imm_in;
        pc_inc   = pc_in + BUS_WIDTH'(1);
        slt_ab   = $signed(rs1_data_in) < $signed(alu_b);
        sltu_ab  = rs1_data_in < alu_b;
        br_eq    = rs1_data_in == rs2_data_in;
        br_lt    = $signed(rs1_data_in) < $signed(rs2_data_in);
        br_ltu   = rs1_data_in < rs2_data_in;
        is_alu   = (instr_type_in[INSTR_TYPE_WIDTH-1:5] == '0) &&
                   (instr_type_in[3:0] != 4'h0) && (instr_type_in[3:0] <= 4'hA);

        case (instr_type_in[3:0])
            4'h1:    alu_res = rs1_data_in + alu_b;
            4'h2:    alu_res = rs1_data_in - alu_b;
            4'h3:    alu_res = rs1_data_in & alu_b;
            4'h4:    alu_res = rs1_data_in | alu_b;
            4'h5:    alu_res = rs1_data_in ^ alu_b;
            4'h6:    alu_res = rs1_data_in << shamt;
            4'h7:    alu_res = rs1_data_in >> shamt;
            4'h8:    alu_res = $unsigned($signed(rs1_data_in) >>> shamt);
            4'h9:    alu_res = {{(BUS_WIDTH-1){1'b0}}, slt_ab};
            4'hA:    alu_res = {{(BUS_WIDTH-1){1'b0}}, sltu_ab};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        dec_result    = '0;
        dec_store     = '0;
        dec_rde       = 1'b0;
        dec_br_taken  = 1'b0;
        dec_br_target = '0;
        dec_is_mul    = 1'b0;
        if (is_alu) begin
            dec_result = alu_res;
            dec_rde    = rde_in;
        end else begin
            case (instr_type_in)
                TypeLw: begin
                    dec_result = addr_sum;
                    dec_rde    = rde_in;
                end
                TypeSw: begin
                    dec_result = addr_sum;
                    dec_store  = rs2_data_in;
                end
                TypeBeq, TypeBne, TypeBlt, TypeBge, TypeBltu, TypeBgeu: begin
                    dec_br_target = pc_imm;
                    case (instr_type_in[2:0])
                        3'd0:    dec_br_taken = br_eq;
                        3'd1:    dec_br_taken = !br_eq;
                        3'd2:    dec_br_taken = br_lt;
                        3'd3:    dec_br_taken = !br_lt;
                        3'd4:    dec_br_taken = br_ltu;
                        default: dec_br_taken = !br_ltu;
                    endcase
                end
                TypeJal, TypeJalr: begin
                    dec_result    = pc_inc;
                    dec_rde       = rde_in;
                    dec_br_taken  = 1'b1;
                    dec_br_target = instr_type_in[0] ? addr_sum : pc_imm;
                end
                TypeLui: begin
                    dec_result = imm_in;
                    dec_rde    = rde_in;
                end
                TypeAuipc: begin
                    dec_result = pc_imm;
                    dec_rde    = rde_in;
                end
                TypeMul: begin
                    dec_rde    = rde_in;
                    dec_is_mul = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle, StFull: begin
                    if (accept) begin
                        state_d = dec_is_mul ? StMul : StFull;
                    end else if (state_q == StFull && out_ready) begin
                        state_d = StIdle;
                    end
                end
                StMul: begin
                    if (mul_done) begin
                        state_d = StFull;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        out_valid = (state_q == StFull);
        in_ready  = reset && !flush && (state_q != StMul) && (!out_valid || out_ready);
        accept    = in_valid && in_ready;
    end

    always_comb begin
        mul_acc_step = mul_acc_q + (mul_mplier_q[0] ? mul_mcand_q : '0);
        mul_done     = (state_q == StMul) && (cnt_q == CntW'(1));
        cnt_d        = cnt_q;
        mul_acc_d    = mul_acc_q;
        mul_mcand_d  = mul_mcand_q;
        mul_mplier_d = mul_mplier_q;
        if (flush) begin
            cnt_d = '0;
        end else if (accept && dec_is_mul) begin
            cnt_d        = CntLoad;
            mul_acc_d    = '0;
            mul_mcand_d  = rs1_data_in;
            mul_mplier_d = rs2_data_in;
        end else if (state_q == StMul) begin
            cnt_d        = cnt_q - CntW'(1);
            mul_acc_d    = mul_acc_step;
            mul_mcand_d  = mul_mcand_q << 1;
            mul_mplier_d = mul_mplier_q >> 1;
        end
    end

    always_comb begin
        pc_d        = pc_q;
        type_d      = type_q;
        rd_d        = rd_q;
        rde_d       = rde_q;
        result_d    = result_q;
        store_d     = store_q;
        br_taken_d  = br_taken_q;
        br_target_d = br_target_q;
        if (accept) begin
            pc_d        = pc_in;
            type_d      = instr_type_in;
            rd_d        = rd_in;
            rde_d       = dec_rde;
            result_d    = dec_result;
            store_d     = dec_store;
            br_taken_d  = dec_br_taken;
            br_target_d = dec_br_target;
        end else if (mul_done && !flush) begin
            result_d = mul_acc_step;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q        <= '0;
            mul_acc_q    <= '0;
            mul_mcand_q  <= '0;
            mul_mplier_q <= '0;
            pc_q         <= '0;
            type_q       <= '0;
            rd_q         <= '0;
            rde_q        <= 1'b0;
            result_q     <= '0;
            store_q      <= '0;
            br_taken_q   <= 1'b0;
            br_target_q  <= '0;
        end else begin
            cnt_q        <= cnt_d;
            mul_acc_q    <= mul_acc_d;
            mul_mcand_q  <= mul_mcand_d;
            mul_mplier_q <= mul_mplier_d;
            pc_q         <= pc_d;
            type_q       <= type_d;
            rd_q         <= rd_d;
            rde_q        <= rde_d;
            result_q     <= result_d;
            store_q      <= store_d;
            br_taken_q   <= br_taken_d;
            br_target_q  <= br_target_d;
        end
    end

    assign pc_out         = pc_q;
    assign instr_type_out = type_q;
    assign rd_out         = rd_q;
    assign rde_out        = rde_q;
    assign result         = result_q;
    assign store_data     = store_q;
    assign br_taken       = br_taken_q;
    assign br_target      = br_target_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: expected results are queued at issue and compared when the
// output slot hands a result downstream.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready;
    logic [31:0] pc_in, imm_in, rs1_data_in, rs2_data_in;
    logic [7:0]  instr_type_in;
    logic [4:0]  rd_in;
    logic        rde_in;
    logic        out_valid, out_ready;
    logic [31:0] pc_out, result, store_data, br_target;
    logic [7:0]  instr_type_out;
    logic [4:0]  rd_out;
    logic        rde_out, br_taken;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] result;
        logic [31:0] store_data;
        logic        br_taken;
        logic [31:0] br_target;
        logic        rde;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    execute_stage #(
        .BUS_WIDTH       (32),
        .REG_WIDTH       (5),
        .INSTR_TYPE_WIDTH(8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .pc_in         (pc_in),
        .instr_type_in (instr_type_in),
        .rd_in         (rd_in),
        .rde_in        (rde_in),
        .imm_in        (imm_in),
        .rs1_data_in   (rs1_data_in),
        .rs2_data_in   (rs2_data_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .pc_out        (pc_out),
        .instr_type_out(instr_type_out),
        .rd_out        (rd_out),
        .rde_out       (rde_out),
        .result        (result),
        .store_data    (store_data),
        .br_taken      (br_taken),
        .br_target     (br_target)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] ty, input logic [31:0] pc, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm, input logic rde);
        in_valid      = 1'b1;
        instr_type_in = ty;
        pc_in         = pc;
        rs1_data_in   = rs1;
        rs2_data_in   = rs2;
        imm_in        = imm;
        rd_in         = ty[4:0];
        rde_in        = rde;
    endtask

    task automatic push(input string tag, input logic [7:0] ty, input logic [31:0] pc,
                        input logic [31:0] res, input logic [31:0] st, input logic brt,
                        input logic [31:0] tgt, input logic rde);
        exp_t e;
        e.tag = tag; e.pc = pc; e.rd = ty[4:0]; e.result = res; e.store_data = st;
        e.br_taken = brt; e.br_target = tgt; e.rde = rde;
        sb.push_back(e);
    endtask

    // Single-cycle op: must be accepted now and show up one cycle later.
    task automatic issue(input string tag, input logic [7:0] ty, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                         input logic [31:0] res, input logic [31:0] st, input logic brt,
                         input logic [31:0] tgt, input logic rde);
        drive(ty, pc, rs1, rs2, imm, 1'b1);
        push(tag, ty, pc, res, st, brt, tgt, rde);
        check({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
        tick();
        check({tag, ".latency"}, {31'b0, out_valid}, 32'd1);
    endtask

    // Scoreboard: compare each result as it is handed downstream.
    always @(negedge clk) begin
        if (reset === 1'b1 && flush === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_checks++;
            assert (sb.size() > 0) n_pass++;
            else $error("FAIL sb_pop: observed result 0x%08h with empty queue, expected none",
                        result);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check({e.tag, ".result"}, result, e.result);
                check({e.tag, ".store_data"}, store_data, e.store_data);
                check({e.tag, ".br_taken"}, {31'b0, br_taken}, {31'b0, e.br_taken});
                check({e.tag, ".br_target"}, br_target, e.br_target);
                check({e.tag, ".rde_out"}, {31'b0, rde_out}, {31'b0, e.rde});
                check({e.tag, ".pc_out"}, pc_out, e.pc);
                check({e.tag, ".rd_out"}, {27'b0, rd_out}, {27'b0, e.rd});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        logic ok, seen;

        reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(8'h01, 32'h0, 32'd1, 32'd1, 32'h0, 1'b1);
        tick();
        tick();
        check("rst.in_ready", {31'b0, in_ready}, 32'd0);
        check("rst.out_valid", {31'b0, out_valid}, 32'd0);
        check("rst.result", result, 32'd0);
        check("rst.br_target", br_target, 32'd0);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("post_rst.in_ready", {31'b0, in_ready}, 32'd1);

        // Back-to-back ALU ops, one per cycle.
        issue("add", 8'h01, 32'h4, 32'd5, 32'd7, 32'h0, 32'd12, 32'h0, 1'b0, 32'h0, 1'b1);
        issue("sub", 8'h02, 32'h5, 32'd3, 32'd5, 32'h0, 32'hFFFF_FFFE, 32'h0, 1'b0, 32'h0, 1'b1);
        issue("sra", 8'h08, 32'h6, 32'h8000_0000, 32'd4, 32'h0, 32'hF800_0000, 32'h0, 1'b0,
              32'h0, 1'b1);
        issue("sltu", 8'h0A, 32'h7, 32'd1, 32'hFFFF_FFFF, 32'h0, 32'd1, 32'h0, 1'b0, 32'h0, 1'b1);
        issue("slt", 8'h09, 32'h8, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'd1, 32'h0, 1'b0, 32'h0, 1'b1);
        issue("subi", 8'h12, 32'h9, 32'd10, 32'd100, 32'd3, 32'd7, 32'h0, 1'b0, 32'h0, 1'b1);
        issue("slli", 8'h16, 32'hA, 32'd1, 32'd0, 32'd31, 32'h8000_0000, 32'h0, 1'b0, 32'h0,
              1'b1);
        issue("blt", 8'h32, 32'h10, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1,
              32'h0C, 1'b0);
        issue("bltu", 8'h34, 32'h10, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0,
              32'h0C, 1'b0);
        issue("jalr", 8'h39, 32'h20, 32'h100, 32'd0, 32'd4, 32'h21, 32'h0, 1'b1, 32'h104, 1'b1);
        issue("nop", 8'h0B, 32'h30, 32'd9, 32'd9, 32'd9, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        in_valid = 1'b0;
        tick();
        check("drain.out_valid", {31'b0, out_valid}, 32'd0);

        // Multiply: ready must stay low for the whole iteration window.
        drive(8'h50, 32'h40, 32'hFFFF_FFFF, 32'd3, 32'h0, 1'b1);
        push("mul", 8'h50, 32'h40, 32'hFFFF_FFFD, 32'h0, 1'b0, 32'h0, 1'b1);
        check("mul.in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        cyc = 1;
        ok = 1'b1;
        while (out_valid !== 1'b1 && cyc < 40) begin
            if (in_ready !== 1'b0) ok = 1'b0;
            tick();
            cyc++;
        end
        check("mul.latency", cyc, 32'd33);
        check("mul.in_ready_low", {31'b0, ok}, 32'd1);
        tick();
        check("mul.drained", {31'b0, out_valid}, 32'd0);

        // Held store with downstream stalled.
        out_ready = 1'b0;
        issue("sw", 8'h21, 32'h50, 32'h40, 32'hAB, 32'd8, 32'h48, 32'hAB, 1'b0, 32'h0, 1'b0);
        in_valid = 1'b0;
        ok = 1'b1;
        repeat (5) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'h48 ||
                store_data !== 32'hAB) ok = 1'b0;
            tick();
        end
        check("sw.stable", {31'b0, ok}, 32'd1);
        check("sw.result_held", result, 32'h48);
        out_ready = 1'b1;
        #1;
        check("sw.in_ready_release", {31'b0, in_ready}, 32'd1);
        tick();
        check("sw.drained", {31'b0, out_valid}, 32'd0);

        // Flush on the 10th multiply iteration.
        drive(8'h50, 32'h60, 32'd7, 32'd9, 32'h0, 1'b1);
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        #1;
        check("flush.in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        #1;
        check("flush.out_valid", {31'b0, out_valid}, 32'd0);
        check("flush.idle", {31'b0, in_ready}, 32'd1);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        check("flush.no_result", {31'b0, seen}, 32'd0);
        issue("add_after_flush", 8'h01, 32'h70, 32'd1, 32'd2, 32'h0, 32'd3, 32'h0, 1'b0, 32'h0,
              1'b1);
        in_valid = 1'b0;
        tick();

        // Reset in the middle of a multiply.
        drive(8'h50, 32'h80, 32'd5, 32'd6, 32'h0, 1'b1);
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        reset = 1'b0;
        #1;
        check("rst_mul.in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        reset = 1'b1;
        #1;
        check("rst_mul.out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_mul.idle", {31'b0, in_ready}, 32'd1);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        check("rst_mul.no_result", {31'b0, seen}, 32'd0);
        issue("add_after_rst", 8'h01, 32'h90, 32'd20, 32'd22, 32'h0, 32'd42, 32'h0, 1'b0, 32'h0,
              1'b1);

        // Flush wins over a full slot with in_valid and out_ready all high.
        drive(8'h01, 32'hA0, 32'd1, 32'd1, 32'h0, 1'b1);
        flush = 1'b1;
        #1;
        check("flush_prio.in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_prio.out_valid", {31'b0, out_valid}, 32'd0);
        tick();
        check("flush_prio.no_accept", {31'b0, out_valid}, 32'd0);
        // The op accepted just before the flush was killed, not delivered.
        if (sb.size() > 0 && sb[sb.size()-1].tag == "add_after_rst") void'(sb.pop_back());

        tick();
        check("sb.empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
